conv_encoder_stream: RTL

//  Streaming convolutional encoder; parametrised successor of the endec encode path.
//  - Runtime code rate 1/n (n <= MAX_CODE_RATE), constraint length K (<= MAX_CONSTR_LEN) and per-output generator polynomials.
//  - Valid/ready on input and output; one symbol per trellis step.
//  - Frame-based: after i_frame_len data bits it appends K-1 zero tail bits to flush, then pulses done.
//  - Sits between the bit source and the channel/Viterbi decoder model.

---
 rtl/conv_enc_pkg.sv | 34 +++
 rtl/conv_encoder_stream_if.sv | 17 +
 rtl/conv_enc_trellis.sv | 55 +++++
 rtl/conv_encoder_stream.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_enc_pkg.sv
// Shared types, defaults and the masked-parity helper for the streaming
// convolutional encoder. Puncturing is compiled in with CONV_ENC_PUNCTURE_EN.
package conv_enc_pkg;

  localparam int unsigned MAX_CODE_RATE_DEF  = 3;
  localparam int unsigned MAX_CONSTR_LEN_DEF = 9;
  localparam int unsigned FRAME_LEN_W_DEF    = 16;
  localparam int unsigned PUNCT_PERIOD_DEF   = 4;

  // Generic width used by the parity helper; callers zero-extend into it,
  // so constraint lengths up to 32 are covered.
  localparam int unsigned POLY_W    = 32;
  localparam int unsigned K_FIELD_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_TAIL  = 2'd2,
    ST_FLUSH = 2'd3
  } enc_state_e;

  // XOR of the generator taps that hit the window, restricted to the low k bits.
  function automatic logic parity_masked(input logic [POLY_W-1:0]    poly,
                                         input logic [POLY_W-1:0]    window,
                                         input logic [K_FIELD_W-1:0] k);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < int'(POLY_W); i++) begin
      acc = acc ^ (poly[i] & window[i] & (i < int'(k)));
    end
    return acc;
  endfunction

endpackage

// File: rtl/conv_encoder_stream_if.sv
// Bit-in / symbol-out valid-ready stream bundle of the convolutional encoder.
// slave = encoder side, master = bit source / symbol sink side.
interface conv_encoder_stream_if #(
  parameter int unsigned CODE_W = conv_enc_pkg::MAX_CODE_RATE_DEF
);
  logic              i_bit;
  logic              i_valid;
  logic              o_ready;
  logic [CODE_W-1:0] o_data;
  logic              o_valid;
  logic              i_out_ready;

  modport slave  (input  i_bit, i_valid, i_out_ready,
                  output o_ready, o_data, o_valid);
  modport master (output i_bit, i_valid, i_out_ready,
                  input  o_ready, o_data, o_valid);
endinterface

// File: rtl/conv_enc_trellis.sv
// Trellis state of the encoder: the shift register of past bits, the window
// {past bits, current bit} and the n generator parities of that window.
// The parities are combinational on the current bit; i_step commits the bit.
module conv_enc_trellis
  import conv_enc_pkg::*;
#(
  parameter int unsigned MAX_CODE_RATE  = MAX_CODE_RATE_DEF,
  parameter int unsigned MAX_CONSTR_LEN = MAX_CONSTR_LEN_DEF,
  parameter int unsigned RATE_W         = $clog2(MAX_CODE_RATE + 1),
  parameter int unsigned K_W            = $clog2(MAX_CONSTR_LEN + 1)
) (
  input  logic                                          sys_clk,
  input  logic                                          rst,
  input  logic                                          i_clear,
  input  logic                                          i_step,
  input  logic                                          i_bit,
  input  logic [RATE_W-1:0]                             i_code_rate,
  input  logic [K_W-1:0]                                i_constr_len,
  input  logic [MAX_CODE_RATE-1:0][MAX_CONSTR_LEN-1:0]  i_gen_poly,
  output logic [MAX_CODE_RATE-1:0]                      o_parity
);

  // w_window[0] is the current bit, w_window[i] the bit i steps earlier.
  logic [MAX_CONSTR_LEN-2:0] r_sr;
  logic [MAX_CONSTR_LEN-1:0] w_window;

  assign w_window = {r_sr, i_bit};

  // Parity per generator; outputs at or above the code rate are held at zero.
  always_comb begin
    o_parity = '0;
    for (int j = 0; j < int'(MAX_CODE_RATE); j++) begin
      if (j < int'(i_code_rate)) begin
        o_parity[j] = parity_masked(POLY_W'(i_gen_poly[j]), POLY_W'(w_window),
                                    K_FIELD_W'(i_constr_len));
      end else begin
        o_parity[j] = 1'b0;
      end
    end
  end

  // Shift register: cleared between frames, shifts one bit per trellis step.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_sr <= '0;
    end else if (i_clear) begin
      r_sr <= '0;
    end else if (i_step) begin
      r_sr <= w_window[MAX_CONSTR_LEN-2:0];
    end else begin
      r_sr <= r_sr;
    end
  end

endmodule

// File: rtl/conv_encoder_stream.sv
// Streaming rate-1/n convolutional encoder with runtime rate, constraint
// length and generators. Each frame is followed by K-1 zero tail bits and a
// one-cycle done pulse. Optional puncturing: define CONV_ENC_PUNCTURE_EN.
module conv_encoder_stream
  import conv_enc_pkg::*;
#(
  parameter int unsigned MAX_CODE_RATE  = MAX_CODE_RATE_DEF,
  parameter int unsigned MAX_CONSTR_LEN = MAX_CONSTR_LEN_DEF,
  parameter int unsigned FRAME_LEN_W    = FRAME_LEN_W_DEF,
  parameter int unsigned PUNCT_PERIOD   = PUNCT_PERIOD_DEF
) (
  input  logic                                               sys_clk,
  input  logic                                               rst,
  input  logic                                               i_start,
  input  logic [$clog2(MAX_CODE_RATE+1)-1:0]                 i_code_rate,
  input  logic [$clog2(MAX_CONSTR_LEN+1)-1:0]                i_constr_len,
  input  logic [MAX_CODE_RATE-1:0][MAX_CONSTR_LEN-1:0]       i_gen_poly,
  input  logic [FRAME_LEN_W-1:0]                             i_frame_len,
  conv_encoder_stream_if.slave                               stream,
  output logic                                               o_busy,
  output logic                                               o_done,
  output logic                                               o_cfg_err
`ifdef CONV_ENC_PUNCTURE_EN
  ,
  input  logic [PUNCT_PERIOD*MAX_CODE_RATE-1:0]              i_punct_pattern,
  output logic [MAX_CODE_RATE-1:0]                           o_sym_mask
`endif
);

  localparam int unsigned RATE_W = $clog2(MAX_CODE_RATE + 1);
  localparam int unsigned K_W    = $clog2(MAX_CONSTR_LEN + 1);

  enc_state_e r_state;
  enc_state_e w_state_nxt;

  // Configuration latched at an accepted start
  logic [RATE_W-1:0]                            r_rate;
  logic [K_W-1:0]                               r_k;
  logic [MAX_CODE_RATE-1:0][MAX_CONSTR_LEN-1:0] r_poly;
  logic [FRAME_LEN_W-1:0]                       r_frame_len;

  logic [FRAME_LEN_W-1:0] r_bit_cnt;
  logic [K_W-1:0]         r_tail_cnt;

  logic [MAX_CODE_RATE-1:0] r_data;
  logic                     r_valid;
  logic                     r_done;
  logic                     r_cfg_err;

  logic                     w_advance;
  logic                     w_cfg_ok;
  logic                     w_start_ok;
  logic                     w_cfg_bad;
  logic                     w_load;
  logic                     w_in_bit;
  logic                     w_ready;
  logic                     w_done_set;
  logic                     w_clear;
  logic [MAX_CODE_RATE-1:0] w_parity;
  logic [MAX_CODE_RATE-1:0] w_rate_mask;
  logic [MAX_CODE_RATE-1:0] w_sym_mask;

  // The output register may take a new symbol when empty or being drained.
  assign w_advance = ~r_valid | stream.i_out_ready;

  assign w_cfg_ok = (i_code_rate != RATE_W'(0)) &&
                    (i_code_rate <= RATE_W'(MAX_CODE_RATE)) &&
                    (i_constr_len >= K_W'(2)) &&
                    (i_constr_len <= K_W'(MAX_CONSTR_LEN)) &&
                    (i_frame_len != FRAME_LEN_W'(0));

  // Next-state and per-cycle control decode
  always_comb begin
    w_state_nxt = r_state;
    w_start_ok  = 1'b0;
    w_cfg_bad   = 1'b0;
    w_load      = 1'b0;
    w_in_bit    = 1'b0;
    w_ready     = 1'b0;
    w_done_set  = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          if (w_cfg_ok) begin
            w_start_ok  = 1'b1;
            w_clear     = 1'b1;
            w_state_nxt = ST_DATA;
          end else begin
            w_cfg_bad = 1'b1;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DATA: begin
        w_ready = w_advance;
        if (stream.i_valid && w_advance) begin
          w_load   = 1'b1;
          w_in_bit = stream.i_bit;
          if (r_bit_cnt == r_frame_len - FRAME_LEN_W'(1)) begin
            w_state_nxt = ST_TAIL;
          end else begin
            w_state_nxt = ST_DATA;
          end
        end else begin
          w_state_nxt = ST_DATA;
        end
      end
      ST_TAIL: begin
        if (w_advance) begin
          w_load = 1'b1;
          if (r_tail_cnt == r_k - K_W'(2)) begin
            w_state_nxt = ST_FLUSH;
          end else begin
            w_state_nxt = ST_TAIL;
          end
        end else begin
          w_state_nxt = ST_TAIL;
        end
      end
      ST_FLUSH: begin
        if (r_valid && stream.i_out_ready) begin
          w_done_set  = 1'b1;
          w_clear     = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_FLUSH;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Config latch; later input changes do not disturb a running frame
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_rate      <= '0;
      r_k         <= '0;
      r_poly      <= '0;
      r_frame_len <= '0;
    end else if (w_start_ok) begin
      r_rate      <= i_code_rate;
      r_k         <= i_constr_len;
      r_poly      <= i_gen_poly;
      r_frame_len <= i_frame_len;
    end
  end

  // Data-bit and tail-bit counters, saturating at their terminal counts
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_bit_cnt  <= '0;
      r_tail_cnt <= '0;
    end else if (w_start_ok) begin
      r_bit_cnt  <= '0;
      r_tail_cnt <= '0;
    end else if (w_load && (r_state == ST_DATA) && (r_bit_cnt != r_frame_len)) begin
      r_bit_cnt <= r_bit_cnt + FRAME_LEN_W'(1);
    end else if (w_load && (r_state == ST_TAIL) && (r_tail_cnt != r_k - K_W'(1))) begin
      r_tail_cnt <= r_tail_cnt + K_W'(1);
    end
  end

  conv_enc_trellis #(
    .MAX_CODE_RATE  (MAX_CODE_RATE),
    .MAX_CONSTR_LEN (MAX_CONSTR_LEN),
    .RATE_W         (RATE_W),
    .K_W            (K_W)
  ) u_trellis (
    .sys_clk      (sys_clk),
    .rst          (rst),
    .i_clear      (w_clear),
    .i_step       (w_load),
    .i_bit        (w_in_bit),
    .i_code_rate  (r_rate),
    .i_constr_len (r_k),
    .i_gen_poly   (r_poly),
    .o_parity     (w_parity)
  );

  // Bits belonging to active generators
  always_comb begin
    w_rate_mask = '0;
    for (int j = 0; j < int'(MAX_CODE_RATE); j++) begin
      w_rate_mask[j] = (j < int'(r_rate));
    end
  end

`ifdef CONV_ENC_PUNCTURE_EN
  localparam int unsigned PCNT_W = (PUNCT_PERIOD > 1) ? $clog2(PUNCT_PERIOD) : 1;

  logic [PUNCT_PERIOD*MAX_CODE_RATE-1:0] r_pattern;
  logic [PCNT_W-1:0]                     r_sym_cnt;
  logic [MAX_CODE_RATE-1:0]              r_sym_mask;

  assign w_sym_mask = r_pattern[int'(r_sym_cnt)*MAX_CODE_RATE +: MAX_CODE_RATE] & w_rate_mask;
  assign o_sym_mask = r_sym_mask;

  // Puncture pattern latch and symbol-position counter over data and tail
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_pattern <= '0;
      r_sym_cnt <= '0;
    end else if (w_start_ok) begin
      r_pattern <= i_punct_pattern;
      r_sym_cnt <= '0;
    end else if (w_load) begin
      if (r_sym_cnt == PCNT_W'(PUNCT_PERIOD - 1)) begin
        r_sym_cnt <= '0;
      end else begin
        r_sym_cnt <= r_sym_cnt + PCNT_W'(1);
      end
    end
  end

  // Mask travels with its symbol through the output register
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_sym_mask <= '0;
    end else if (w_load) begin
      r_sym_mask <= w_sym_mask;
    end
  end
`else
  assign w_sym_mask = w_rate_mask;
`endif

  // Single-stage output register; holds while the sink stalls
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_data  <= w_parity & w_sym_mask;
      r_valid <= 1'b1;
    end else if (stream.i_out_ready) begin
      r_valid <= 1'b0;
    end
  end

  // One-cycle status pulses
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_done    <= w_done_set;
      r_cfg_err <= w_cfg_bad;
    end
  end

  assign stream.o_data  = r_data;
  assign stream.o_valid = r_valid;
  assign stream.o_ready = w_ready;
  assign o_busy         = (r_state != ST_IDLE);
  assign o_done         = r_done;
  assign o_cfg_err      = r_cfg_err;

endmodule
